chacha_block_engine: RTL
========================

Name: chacha_block_engine

Overview:
- Parametrised successor to the single-block ChaCha block function.
- Accepts one key/nonce/counter job and produces `num_blocks` consecutive 512-bit keystream blocks. Each block is the round permutation plus the feed-forward addition of the initial state.
- Round count and quarter-round parallelism are configurable. Both the request and the output side use valid/ready handshakes.
- Sits between the key/nonce setup logic and the keystream serializer/XOR stage.

Parameters:
- ROUNDS, 20, total rounds; legal values 8, 12, 20 (even only, elaboration error otherwise).
- QR_LANES, 4, quarter-rounds evaluated per cycle; 4 = one half-round (column or diagonal) per cycle, 8 = one full double-round per cycle.
- NBLK_W, 16, width of the block-count request field.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- key  in  8x32  256-bit key, word 0 = bytes 0..3 little-endian
- nonce  in  3x32  96-bit nonce
- counter_init  in  32  block counter for the first block
- num_blocks  in  NBLK_W  blocks to generate; 0 is treated as 1
- req_valid  in  1  job request valid
- req_ready  out  1  high only in IDLE
- out_valid  out  1  keystream block valid
- out_ready  in  1  downstream accepts block
- out_block  out  16x32  keystream block, word 0 first
- out_counter  out  32  counter value used for out_block
- out_last  out  1  marks the final block of the job
- busy  out  1  high whenever state is not IDLE
- ctr_overflow  out  1  sticky error; cleared by rst or next accepted request

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; working and initial state registers cleared.
- Initial state layout:
  - words 0..3 = constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574
  - words 4..11 = key
  - word 12 = counter
  - words 13..15 = nonce
- FSM:
  - IDLE: on req_valid&&req_ready, capture key, nonce, counter_init and num_blocks into job registers; clear ctr_overflow → LOAD.
  - LOAD: build the initial state; copy it into the working state; round_cnt=0 → ROUND.
  - ROUND: each cycle apply QR_LANES quarter-rounds. Half-rounds alternate column then diagonal, starting with column. Stay for ROUNDS*4/QR_LANES cycles → ADD.
  - ADD: out_block = working + initial, per word mod 2^32; out_counter = current counter; out_valid=1 → HOLD.
  - HOLD: out_block and out_valid stay stable until out_ready.
    - On transfer with blocks remaining: counter+1 → LOAD.
    - On transfer of the last block → IDLE.
- Latency: out_valid rises ROUNDS*4/QR_LANES + 2 cycles after the accepting edge (22 cycles at default parameters).
- Throughput: one block per ROUNDS*4/QR_LANES + 3 cycles when out_ready is held high.
- out_last=1 alongside out_valid on the final block of the job.
- Counter wrap: if a block using counter 0xFFFFFFFF is transferred and further blocks remain, set ctr_overflow, end the job and return to IDLE. The counter never wraps to 0.
- out_valid must not drop without out_ready; req_ready=0 for the whole job.
- Changes on key/nonce inputs after acceptance have no effect.
- rst mid-job: abort immediately to the reset values; no partial block is presented.

Optional Feature:
- Macro CHACHA_ZEROIZE_EN.
- Defined: on leaving HOLD into IDLE (normal end, overflow or abort), captured key, initial state, working state and out_block are zeroed in that same cycle.
- Defined: out_block reads 0 whenever out_valid=0.
- Not defined: these registers retain their last contents; out_block is only meaningful while out_valid=1.

Decomposition:
- Package chacha_pkg holds:
  - word_t (32-bit) and state_t (16 x word_t)
  - the four sigma constants
  - a function mapping a half-round index to quarter-round word indices
- One natural sub-module: chacha_qround, a combinational quarter-round (a,b,c,d in/out; add, xor, rotl 16/12/8/7).
- Instantiate QR_LANES copies of chacha_qround.

Test Plan:
- RFC 8439 §2.3.2 vector:
  - stimulus: key words 0x03020100..0x1f1e1d1c, nonce {0x09000000, 0x4a000000, 0x00000000}, counter_init=1, num_blocks=1, out_ready=1
  - required: out_block word0=0xe4e7f110, word15=0x4e3c50a2; out_counter=1; out_last=1; out_valid exactly 22 cycles after acceptance.
- Same vector with QR_LANES=8 → identical output, latency 12 cycles.
- num_blocks=3, counter_init=7, out_ready toggled randomly → out_counter 7, 8, 9; out_block stable while stalled; out_last only on the third block.
- counter_init=0xFFFFFFFE, num_blocks=4 → two blocks (counters 0xFFFFFFFE, 0xFFFFFFFF), then ctr_overflow=1 and return to IDLE.
- rst asserted during ROUND of a 5-block job → next cycle req_ready=1, busy=0, out_valid=0; a new request completes correctly.
- With CHACHA_ZEROIZE_EN defined: after the final transfer, out_block=0 and internal key registers read 0.

Source files
------------

// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared word/state types, sigma constants and quarter-round index map for the ChaCha engine
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [15:0] state_t;

    localparam word_t SIGMA0 = 32'h61707865;
    localparam word_t SIGMA1 = 32'h3320646e;
    localparam word_t SIGMA2 = 32'h79622d32;
    localparam word_t SIGMA3 = 32'h6b206574;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_ADD,
        S_HOLD
    } engine_state_e;

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Word index of element `row` (a,b,c,d) of quarter-round `lane`; diagonal
    // half-rounds shift the column by the row number.
    function automatic logic [3:0] qr_index(input logic diag, input logic [1:0] lane,
                                            input logic [1:0] row);
        logic [1:0] col;
        col = diag ? lane + row : lane;
        return {row, col};
    endfunction

endpackage

// File: rtl/chacha_block_engine_if.sv
// rtl/chacha_block_engine_if.sv - job request and keystream output handshake bundle
interface chacha_block_engine_if #(
    parameter int NBLK_W = 16
);
    import chacha_pkg::*;

    word_t [7:0]        key;
    word_t [2:0]        nonce;
    word_t              counter_init;
    logic [NBLK_W-1:0]  num_blocks;
    logic               req_valid;
    logic               req_ready;
    logic               out_valid;
    logic               out_ready;
    state_t             out_block;
    word_t              out_counter;
    logic               out_last;
    logic               busy;
    logic               ctr_overflow;

    modport master (
        output key, nonce, counter_init, num_blocks, req_valid, out_ready,
        input  req_ready, out_valid, out_block, out_counter, out_last, busy, ctr_overflow
    );

    modport slave (
        input  key, nonce, counter_init, num_blocks, req_valid, out_ready,
        output req_ready, out_valid, out_block, out_counter, out_last, busy, ctr_overflow
    );

endinterface

// File: rtl/chacha_qround.sv
// rtl/chacha_qround.sv - combinational ChaCha quarter-round
module chacha_qround
    import chacha_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    input  word_t c_i,
    input  word_t d_i,
    output word_t a_o,
    output word_t b_o,
    output word_t c_o,
    output word_t d_o
);

    word_t a1, b1, c1, d1;

    always_comb begin
        a1  = a_i + b_i;
        d1  = rotl(d_i ^ a1, 16);
        c1  = c_i + d1;
        b1  = rotl(b_i ^ c1, 12);
        a_o = a1 + b1;
        d_o = rotl(d1 ^ a_o, 8);
        c_o = c1 + d_o;
        b_o = rotl(b1 ^ c_o, 7);
    end

endmodule

// File: rtl/chacha_block_engine.sv
// rtl/chacha_block_engine.sv - multi-block ChaCha keystream engine; CHACHA_ZEROIZE_EN wipes secrets at job end
module chacha_block_engine
    import chacha_pkg::*;
#(
    parameter int ROUNDS   = 20,
    parameter int QR_LANES = 4,
    parameter int NBLK_W   = 16
) (
    input  logic clk,
    input  logic rst,
    chacha_block_engine_if.slave bus
);

    localparam int ROUND_CYC = ROUNDS * 4 / QR_LANES;
    localparam int NSTG      = QR_LANES / 4;
    localparam int RC_W      = $clog2(ROUND_CYC);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_block_engine: ROUNDS must be 8, 12 or 20");
    end
    if (!(QR_LANES == 4 || QR_LANES == 8)) begin : g_bad_lanes
        $error("chacha_block_engine: QR_LANES must be 4 or 8");
    end

    engine_state_e       state_q, state_d;
    word_t [7:0]         key_q, key_d;
    word_t [2:0]         nonce_q, nonce_d;
    word_t               ctr_q, ctr_d;
    logic [NBLK_W-1:0]   blk_left_q, blk_left_d;
    state_t              init_q, init_d;
    state_t              work_q, work_d;
    logic [RC_W-1:0]     round_cnt_q, round_cnt_d;
    state_t              out_block_q, out_block_d;
    word_t               out_counter_q, out_counter_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                ovf_q, ovf_d;
    state_t              rnd_out;

    function automatic state_t build_state(input word_t [7:0] k, input word_t c,
                                           input word_t [2:0] n);
        state_t s;
        s[0] = SIGMA0;
        s[1] = SIGMA1;
        s[2] = SIGMA2;
        s[3] = SIGMA3;
        for (int i = 0; i < 8; i++) s[4+i] = k[i];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[i];
        return s;
    endfunction

    // One stage per half-round evaluated this cycle; with 8 lanes the column
    // stage feeds the diagonal stage, otherwise round_cnt parity picks the kind.
    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        state_t            st_in, st_out;
        logic              diag;
        word_t [3:0][3:0]  qi, qo;

        if (s == 0) begin : g_src
            assign st_in = work_q;
        end else begin : g_src
            assign st_in = g_stage[s-1].st_out;
        end

        assign diag = (NSTG == 2) ? (s == 1) : round_cnt_q[0];

        always_comb begin
            for (int l = 0; l < 4; l++)
                for (int k = 0; k < 4; k++)
                    qi[l][k] = st_in[qr_index(diag, 2'(l), 2'(k))];
        end

        for (genvar l = 0; l < 4; l++) begin : g_lane
            chacha_qround u_qr (
                .a_i(qi[l][0]), .b_i(qi[l][1]), .c_i(qi[l][2]), .d_i(qi[l][3]),
                .a_o(qo[l][0]), .b_o(qo[l][1]), .c_o(qo[l][2]), .d_o(qo[l][3])
            );
        end

        always_comb begin
            st_out = st_in;
            for (int l = 0; l < 4; l++)
                for (int k = 0; k < 4; k++)
                    st_out[qr_index(diag, 2'(l), 2'(k))] = qo[l][k];
        end
    end

    assign rnd_out = g_stage[NSTG-1].st_out;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        nonce_d       = nonce_q;
        ctr_d         = ctr_q;
        blk_left_d    = blk_left_q;
        init_d        = init_q;
        work_d        = work_q;
        round_cnt_d   = round_cnt_q;
        out_block_d   = out_block_q;
        out_counter_d = out_counter_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        ovf_d         = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    key_d      = bus.key;
                    nonce_d    = bus.nonce;
                    ctr_d      = bus.counter_init;
                    blk_left_d = (bus.num_blocks == '0) ? NBLK_W'(1) : bus.num_blocks;
                    ovf_d      = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                init_d      = build_state(key_q, ctr_q, nonce_q);
                work_d      = build_state(key_q, ctr_q, nonce_q);
                round_cnt_d = '0;
                state_d     = S_ROUND;
            end
            S_ROUND: begin
                work_d      = rnd_out;
                round_cnt_d = round_cnt_q + 1'b1;
                if (round_cnt_q == RC_W'(ROUND_CYC - 1)) state_d = S_ADD;
            end
            S_ADD: begin
                for (int i = 0; i < 16; i++) out_block_d[i] = work_q[i] + init_q[i];
                out_counter_d = ctr_q;
                out_valid_d   = 1'b1;
                out_last_d    = (blk_left_q == NBLK_W'(1));
                state_d       = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (blk_left_q == NBLK_W'(1)) begin
                        state_d = S_IDLE;
                    end else if (ctr_q == 32'hFFFF_FFFF) begin
                        // Never wrap the counter into keystream already issued.
                        ovf_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ctr_d      = ctr_q + 32'd1;
                        blk_left_d = blk_left_q - NBLK_W'(1);
                        state_d    = S_LOAD;
                    end
`ifdef CHACHA_ZEROIZE_EN
                    out_block_d = '0;
                    if (state_d == S_IDLE) begin
                        key_d  = '0;
                        init_d = '0;
                        work_d = '0;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            key_q         <= '0;
            nonce_q       <= '0;
            ctr_q         <= '0;
            blk_left_q    <= '0;
            init_q        <= '0;
            work_q        <= '0;
            round_cnt_q   <= '0;
            out_block_q   <= '0;
            out_counter_q <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            nonce_q       <= nonce_d;
            ctr_q         <= ctr_d;
            blk_left_q    <= blk_left_d;
            init_q        <= init_d;
            work_q        <= work_d;
            round_cnt_q   <= round_cnt_d;
            out_block_q   <= out_block_d;
            out_counter_q <= out_counter_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            ovf_q         <= ovf_d;
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_block    = out_block_q;
    assign bus.out_counter  = out_counter_q;
    assign bus.out_last     = out_last_q;
    assign bus.ctr_overflow = ovf_q;

endmodule
